nvm_burst_ctrl: RTL

- Burst controller directly upstream of the ReRAM NVM macro; sole driver of its we/addr/data_in, sole consumer of its data_out/ack.
- Converts a start/base/length command into sequential single-word NVM accesses.
- Read bursts: NVM words go out through a valid/ready stream with a small credit-managed FIFO.
- Write bursts: an inbound valid/ready stream is programmed into consecutive NVM addresses.

---
 rtl/nvm_burst_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nvm_burst_ctrl.sv
// nvm_burst_ctrl: turns a start/base/length command into single-word accesses
// on the ReRAM NVM macro. Read bursts go out through a credit-managed return
// FIFO onto a valid/ready stream; write bursts take an inbound valid/ready
// stream and program consecutive NVM addresses.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start; all NVM outputs held, nvm_we low
//   RD     | issuing reads, collecting returns into FIFO, draining stream
//   WR     | accepting stream beats, one NVM write per accepted beat
//   DONE   | one-cycle completion pulse, then back to IDLE
//
// NVM pipeline: a word issued in cycle t is registered onto nvm_* during
// t+1 and its read data / ack come back in t+2. Two valid bits track those
// two stages, so at most two reads are ever in flight. A nacked read flushes
// the younger in-flight read and rewinds the address counter, which keeps
// the returned stream strictly in address order.

module nvm_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  wr_mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  nvm_we,
  output logic [ADDR_WIDTH-1:0] nvm_addr,
  output logic [DATA_WIDTH-1:0] nvm_wdata,
  input  logic [DATA_WIDTH-1:0] nvm_rdata,
  input  logic                  nvm_ack
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] naddr_q, naddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  p1_v_q, p1_v_d;
  logic                  p2_v_q, p2_v_d;
  logic [ADDR_WIDTH-1:0] p2_addr_q, p2_addr_d;

  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic        in_rd;
  logic        rem_zero;
  logic [CW:0] occ;
  logic        push;
  logic        pop;
  logic        rd_nack;
  logic        issue;
  logic        wr_beat;
  logic        load;
  logic        rd_drained;

  // Occupancy seen by the credit check: stored words plus words in flight.
  assign in_rd      = (state_q == S_RD);
  assign rem_zero   = (rem_q == '0);
  assign occ        = {1'b0, cnt_q} + (CW+1)'(p1_v_q) + (CW+1)'(p2_v_q);
  assign push       = in_rd && p2_v_q && nvm_ack;
  assign rd_nack    = in_rd && p2_v_q && !nvm_ack;
  assign pop        = m_valid && m_ready;
  assign issue      = in_rd && !rem_zero && (occ < DEPTH_C) && !rd_nack;
  assign wr_beat    = s_valid && s_ready;
  assign load       = (state_q == S_IDLE) && start && (burst_len != '0);
  assign rd_drained = rem_zero && !p1_v_q && !p2_v_q && (cnt_q == '0) && !push;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len == '0) begin
            state_d = S_DONE;
          end else if (wr_mode) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (rd_drained) begin
          state_d = S_DONE;
        end
      end
      S_WR: begin
        // Last beat went onto nvm_* this cycle; NVM commits it at this edge.
        if (rem_zero) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state and FIFO occupancy.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    s_ready = (state_q == S_WR) && !rem_zero;
    m_valid = (cnt_q != '0);
    m_data  = m_valid ? fifo_mem[rptr_q] : '0;
  end

  assign nvm_we    = we_q;
  assign nvm_addr  = naddr_q;
  assign nvm_wdata = wdata_q;

  // Datapath next values: address/remaining counters, NVM regs, FIFO pointers.
  always_comb begin
    addr_d    = addr_q;
    rem_d     = rem_q;
    we_d      = 1'b0;
    naddr_d   = naddr_q;
    wdata_d   = wdata_q;
    p1_v_d    = issue;
    p2_v_d    = p1_v_q && !rd_nack;
    p2_addr_d = naddr_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;

    if (load) begin
      addr_d = base_addr;
      rem_d  = burst_len;
    end

    if (issue) begin
      naddr_d = addr_q;
      addr_d  = addr_q + ADDR_WIDTH'(1);
      rem_d   = rem_q - (ADDR_WIDTH+1)'(1);
    end

    // Failed read: give back its credit and that of the younger read behind
    // it, and restart from the failed address so order is preserved.
    if (rd_nack) begin
      addr_d = p2_addr_q;
      rem_d  = rem_q + (ADDR_WIDTH+1)'(1) + (ADDR_WIDTH+1)'(p1_v_q);
    end

    if (wr_beat) begin
      we_d    = 1'b1;
      naddr_d = addr_q;
      wdata_d = s_data;
      addr_d  = addr_q + ADDR_WIDTH'(1);
      rem_d   = rem_q - (ADDR_WIDTH+1)'(1);
    end

    if (push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      rem_q     <= '0;
      we_q      <= 1'b0;
      naddr_q   <= '0;
      wdata_q   <= '0;
      p1_v_q    <= 1'b0;
      p2_v_q    <= 1'b0;
      p2_addr_q <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      we_q      <= we_d;
      naddr_q   <= naddr_d;
      wdata_q   <= wdata_d;
      p1_v_q    <= p1_v_d;
      p2_v_q    <= p2_v_d;
      p2_addr_q <= p2_addr_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Return FIFO storage; contents are only visible while cnt_q is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr_q] <= nvm_rdata;
    end
  end

endmodule
